// File: rtl/aq_mmu_sysmap_arb_pkg.sv
// ============================================================================
// Module      : aq_mmu_sysmap_arb_pkg
// Description : Shared constants, owner encoding and helpers for the
//               system-map request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aq_mmu_sysmap_arb_pkg;

   localparam int SYSMAP_REQ_IFU = 0;
   localparam int SYSMAP_REQ_LSU = 1;
   localparam int SYSMAP_REQ_PTW = 2;
   localparam int SYSMAP_NREQ    = 3;

   localparam int SYSMAP_PA_W    = 28;
   localparam int SYSMAP_FLG_W   = 5;

   // Attribute value the lookup returns when no range matches.
   localparam logic [4:0] SYSMAP_FLG_NOHIT = 5'b10011;

   typedef enum logic [1:0] {
      SYSMAP_OWN_IFU = 2'd0,
      SYSMAP_OWN_LSU = 2'd1,
      SYSMAP_OWN_PTW = 2'd2
   } sysmap_own_e;

   function automatic sysmap_own_e sysmap_own_enc(input logic [SYSMAP_NREQ-1:0] oh);
      if (oh[SYSMAP_REQ_PTW])
         return SYSMAP_OWN_PTW;
      else if (oh[SYSMAP_REQ_LSU])
         return SYSMAP_OWN_LSU;
      else
         return SYSMAP_OWN_IFU;
   endfunction

   function automatic logic [SYSMAP_NREQ-1:0] sysmap_own_dec(input sysmap_own_e own);
      case (own)
         SYSMAP_OWN_LSU: return 3'b010;
         SYSMAP_OWN_PTW: return 3'b100;
         default:        return 3'b001;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/aq_mmu_sysmap_rr_arb.sv
// ============================================================================
// Module      : aq_mmu_sysmap_rr_arb
// Description : Three-way round-robin arbiter with one-hot pointer register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aq_mmu_sysmap_rr_arb
   import aq_mmu_sysmap_arb_pkg::*;
(
   input  logic                   forever_cpuclk,
   input  logic                   cpurst,
   input  logic [SYSMAP_NREQ-1:0] vld_i,
   input  logic                   flush_i,
   output logic [SYSMAP_NREQ-1:0] gnt_o
);

   logic [SYSMAP_NREQ-1:0] ptr_q;
   logic [SYSMAP_NREQ-1:0] ptr_d;
   logic [SYSMAP_NREQ-1:0] gnt_d;

   // The pointed requester wins, then the following indices with wrap-around.
   always_comb begin
      gnt_d = '0;
      case (ptr_q)
         3'b010: begin
            if      (vld_i[SYSMAP_REQ_LSU]) gnt_d = 3'b010;
            else if (vld_i[SYSMAP_REQ_PTW]) gnt_d = 3'b100;
            else if (vld_i[SYSMAP_REQ_IFU]) gnt_d = 3'b001;
         end
         3'b100: begin
            if      (vld_i[SYSMAP_REQ_PTW]) gnt_d = 3'b100;
            else if (vld_i[SYSMAP_REQ_IFU]) gnt_d = 3'b001;
            else if (vld_i[SYSMAP_REQ_LSU]) gnt_d = 3'b010;
         end
         default: begin
            if      (vld_i[SYSMAP_REQ_IFU]) gnt_d = 3'b001;
            else if (vld_i[SYSMAP_REQ_LSU]) gnt_d = 3'b010;
            else if (vld_i[SYSMAP_REQ_PTW]) gnt_d = 3'b100;
         end
      endcase
      if (cpurst || flush_i)
         gnt_d = '0;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (|gnt_d)
         ptr_d = {gnt_d[1:0], gnt_d[2]};
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst)
         ptr_q <= 3'b001;
      else
         ptr_q <= ptr_d;
   end

   assign gnt_o = gnt_d;

endmodule

`default_nettype wire

// File: rtl/aq_mmu_sysmap_arb.sv
// ============================================================================
// Module      : aq_mmu_sysmap_arb
// Description : Round-robin arbiter and pipeline around the system-map lookup.
//               Optional extra response stage: AQ_MMU_SYSMAP_RSP_PIPE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aq_mmu_sysmap_arb
   import aq_mmu_sysmap_arb_pkg::*;
#(
   parameter int PA_W  = SYSMAP_PA_W,
   parameter int FLG_W = SYSMAP_FLG_W
)(
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             mmu_sysmap_flush,
   input  logic             ifu_sysmap_req_vld,
   input  logic [PA_W-1:0]  ifu_sysmap_req_pa,
   input  logic             lsu_sysmap_req_vld,
   input  logic [PA_W-1:0]  lsu_sysmap_req_pa,
   input  logic             ptw_sysmap_req_vld,
   input  logic [PA_W-1:0]  ptw_sysmap_req_pa,
   output logic             sysmap_ifu_req_rdy,
   output logic             sysmap_lsu_req_rdy,
   output logic             sysmap_ptw_req_rdy,
   output logic             sysmap_ifu_rsp_vld,
   output logic             sysmap_lsu_rsp_vld,
   output logic             sysmap_ptw_rsp_vld,
   output logic [FLG_W-1:0] sysmap_rsp_flg,
   output logic [PA_W-1:0]  mmu_sysmap_pa,
   input  logic [FLG_W-1:0] sysmap_mmu_flg
);

   logic [SYSMAP_NREQ-1:0] req_vld;
   logic [SYSMAP_NREQ-1:0] gnt;
   logic [PA_W-1:0]        a_pa_d;

   logic                   a_vld_q;
   logic [PA_W-1:0]        a_pa_q;
   sysmap_own_e            a_own_q;
   logic                   r_vld_q;
   sysmap_own_e            r_own_q;
   logic [FLG_W-1:0]       r_flg_q;

   logic                   out_vld;
   sysmap_own_e            out_own;
   logic [FLG_W-1:0]       out_flg;
   logic [SYSMAP_NREQ-1:0] rsp_vld;

   assign req_vld = {ptw_sysmap_req_vld, lsu_sysmap_req_vld, ifu_sysmap_req_vld};

   aq_mmu_sysmap_rr_arb u_rr_arb (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .vld_i          (req_vld),
      .flush_i        (mmu_sysmap_flush),
      .gnt_o          (gnt)
   );

   assign sysmap_ifu_req_rdy = gnt[SYSMAP_REQ_IFU];
   assign sysmap_lsu_req_rdy = gnt[SYSMAP_REQ_LSU];
   assign sysmap_ptw_req_rdy = gnt[SYSMAP_REQ_PTW];

   always_comb begin
      a_pa_d = ifu_sysmap_req_pa;
      if (gnt[SYSMAP_REQ_LSU])
         a_pa_d = lsu_sysmap_req_pa;
      if (gnt[SYSMAP_REQ_PTW])
         a_pa_d = ptw_sysmap_req_pa;
   end

   // Grants are already suppressed under flush, so a_vld clears naturally.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         a_vld_q <= 1'b0;
         a_pa_q  <= '0;
         a_own_q <= SYSMAP_OWN_IFU;
      end else begin
         a_vld_q <= |gnt;
         if (|gnt) begin
            a_pa_q  <= a_pa_d;
            a_own_q <= sysmap_own_enc(gnt);
         end
      end
   end

   assign mmu_sysmap_pa = a_pa_q;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_vld_q <= 1'b0;
         r_own_q <= SYSMAP_OWN_IFU;
         r_flg_q <= '0;
      end else begin
         r_vld_q <= a_vld_q & ~mmu_sysmap_flush;
         r_own_q <= a_own_q;
         r_flg_q <= sysmap_mmu_flg;
      end
   end

`ifdef AQ_MMU_SYSMAP_RSP_PIPE_EN
   logic             b_vld_q;
   sysmap_own_e      b_own_q;
   logic [FLG_W-1:0] b_flg_q;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         b_vld_q <= 1'b0;
         b_own_q <= SYSMAP_OWN_IFU;
         b_flg_q <= '0;
      end else begin
         b_vld_q <= r_vld_q & ~mmu_sysmap_flush;
         b_own_q <= r_own_q;
         b_flg_q <= r_flg_q;
      end
   end

   assign out_vld = b_vld_q;
   assign out_own = b_own_q;
   assign out_flg = b_flg_q;
`else
   assign out_vld = r_vld_q;
   assign out_own = r_own_q;
   assign out_flg = r_flg_q;
`endif

   assign rsp_vld            = out_vld ? sysmap_own_dec(out_own) : '0;
   assign sysmap_ifu_rsp_vld = rsp_vld[SYSMAP_REQ_IFU];
   assign sysmap_lsu_rsp_vld = rsp_vld[SYSMAP_REQ_LSU];
   assign sysmap_ptw_rsp_vld = rsp_vld[SYSMAP_REQ_PTW];
   assign sysmap_rsp_flg     = out_flg;

endmodule

`default_nettype wire
